// File: rtl/uart_wb_slave.sv
// UART with a zero-wait-state 8-bit register port: 8N1 receiver and transmitter,
// BAUD_DIV clock cycles per bit, level interrupt on received data.
// Optional build macro UART_TX_IRQ_EN adds a tx_done status bit (bit 4),
// a tx_ie control bit (bit 1) and the matching interrupt term.
module uart_wb_slave #(
  parameter int unsigned BAUD_DIV = 434
) (
  input  logic       wb_clk_i,
  input  logic       rst_n_i,
  input  logic       wb_cyc_i,
  input  logic       wb_we_i,
  input  logic [1:0] wb_addr_i,
  input  logic [7:0] wb_datw_i,
  output logic [7:0] wb_datr_o,
  output logic       int_o,
  input  logic       rx_i,
  output logic       tx_o
);

  localparam logic [15:0] BIT_RELOAD  = 16'(BAUD_DIV - 1);
  localparam logic [15:0] HALF_RELOAD = 16'(BAUD_DIV / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  // Bus decode: every edge with wb_cyc_i high is one complete access.
  logic rd_data, rd_status, wr_data, wr_ctrl;
  assign rd_data   = wb_cyc_i & ~wb_we_i & (wb_addr_i == 2'd0);
  assign rd_status = wb_cyc_i & ~wb_we_i & (wb_addr_i == 2'd1);
  assign wr_data   = wb_cyc_i &  wb_we_i & (wb_addr_i == 2'd0);
  assign wr_ctrl   = wb_cyc_i &  wb_we_i & (wb_addr_i == 2'd2);

  // Register state
  logic [7:0] rx_data;
  logic       rx_valid, overrun, frame_err, rx_ie;
  logic       tx_busy;
  logic       tx_done, tx_ie;

  // ---------------------------------------------------------------------------
  // RX input synchronizer plus one history flop for falling-edge detection
  // ---------------------------------------------------------------------------
  logic rx_meta, rx_sync, rx_prev;

  // Two-flop synchronizer; rx_prev holds the previous synchronized sample.
  always_ff @(posedge wb_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // ---------------------------------------------------------------------------
  // RX FSM
  // ---------------------------------------------------------------------------
  rx_state_t   rx_state, rx_state_nx;
  logic [15:0] rx_cnt, rx_cnt_nx;
  logic [2:0]  rx_bits, rx_bits_nx;
  logic [7:0]  rx_shift, rx_shift_nx;
  logic        rx_done, rx_stop_ok;

  // RX state, bit counter and shift register.
  always_ff @(posedge wb_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bits  <= '0;
      rx_shift <= '0;
    end else begin
      rx_state <= rx_state_nx;
      rx_cnt   <= rx_cnt_nx;
      rx_bits  <= rx_bits_nx;
      rx_shift <= rx_shift_nx;
    end
  end

  // RX next state: half-bit wait to the start-bit centre, then full bit periods.
  always_comb begin
    rx_state_nx = rx_state;
    rx_cnt_nx   = rx_cnt;
    rx_bits_nx  = rx_bits;
    rx_shift_nx = rx_shift;
    rx_done     = 1'b0;
    rx_stop_ok  = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (rx_prev && !rx_sync) begin
          rx_state_nx = RX_START;
          rx_cnt_nx   = HALF_RELOAD;
        end
      end
      RX_START: begin
        if (rx_cnt != '0) begin
          rx_cnt_nx = rx_cnt - 16'd1;
        end else if (rx_sync) begin
          rx_state_nx = RX_IDLE;
        end else begin
          rx_state_nx = RX_DATA;
          rx_cnt_nx   = BIT_RELOAD;
          rx_bits_nx  = '0;
        end
      end
      RX_DATA: begin
        if (rx_cnt != '0) begin
          rx_cnt_nx = rx_cnt - 16'd1;
        end else begin
          rx_shift_nx = {rx_sync, rx_shift[7:1]};
          rx_cnt_nx   = BIT_RELOAD;
          if (rx_bits == 3'd7) rx_state_nx = RX_STOP;
          else                 rx_bits_nx  = rx_bits + 3'd1;
        end
      end
      RX_STOP: begin
        if (rx_cnt != '0) begin
          rx_cnt_nx = rx_cnt - 16'd1;
        end else begin
          rx_state_nx = RX_IDLE;
          rx_done     = 1'b1;
          rx_stop_ok  = rx_sync;
        end
      end
      default: rx_state_nx = RX_IDLE;
    endcase
  end

  // Receive status: a completing byte takes priority over a same-edge data read,
  // and that read counts as consuming the old byte, so no overrun is flagged.
  always_ff @(posedge wb_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (rd_status) begin
        overrun   <= 1'b0;
        frame_err <= 1'b0;
      end
      if (rx_done && rx_stop_ok) begin
        rx_data  <= rx_shift;
        rx_valid <= 1'b1;
        if (rx_valid && !rd_data) overrun <= 1'b1;
      end else begin
        if (rx_done) frame_err <= 1'b1;
        if (rd_data) rx_valid  <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // TX FSM
  // ---------------------------------------------------------------------------
  tx_state_t   tx_state, tx_state_nx;
  logic [15:0] tx_cnt, tx_cnt_nx;
  logic [2:0]  tx_bits, tx_bits_nx;
  logic [7:0]  tx_shift, tx_shift_nx;
  logic        tx_line, tx_line_nx;
  logic        tx_end;

  assign tx_busy = (tx_state != TX_IDLE);
  assign tx_o    = tx_line;

  // TX state, counter, shift register and registered serial line.
  always_ff @(posedge wb_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bits  <= '0;
      tx_shift <= '0;
      tx_line  <= 1'b1;
    end else begin
      tx_state <= tx_state_nx;
      tx_cnt   <= tx_cnt_nx;
      tx_bits  <= tx_bits_nx;
      tx_shift <= tx_shift_nx;
      tx_line  <= tx_line_nx;
    end
  end

  // TX next state: line value for each bit is loaded at the edge that starts it.
  always_comb begin
    tx_state_nx = tx_state;
    tx_cnt_nx   = tx_cnt;
    tx_bits_nx  = tx_bits;
    tx_shift_nx = tx_shift;
    tx_line_nx  = tx_line;
    tx_end      = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        if (wr_data) begin
          tx_state_nx = TX_START;
          tx_cnt_nx   = BIT_RELOAD;
          tx_shift_nx = wb_datw_i;
          tx_bits_nx  = '0;
          tx_line_nx  = 1'b0;
        end
      end
      TX_START: begin
        if (tx_cnt != '0) begin
          tx_cnt_nx = tx_cnt - 16'd1;
        end else begin
          tx_state_nx = TX_DATA;
          tx_cnt_nx   = BIT_RELOAD;
          tx_line_nx  = tx_shift[0];
          tx_shift_nx = {1'b0, tx_shift[7:1]};
          tx_bits_nx  = '0;
        end
      end
      TX_DATA: begin
        if (tx_cnt != '0) begin
          tx_cnt_nx = tx_cnt - 16'd1;
        end else begin
          tx_cnt_nx = BIT_RELOAD;
          if (tx_bits == 3'd7) begin
            tx_state_nx = TX_STOP;
            tx_line_nx  = 1'b1;
          end else begin
            tx_line_nx  = tx_shift[0];
            tx_shift_nx = {1'b0, tx_shift[7:1]};
            tx_bits_nx  = tx_bits + 3'd1;
          end
        end
      end
      TX_STOP: begin
        if (tx_cnt != '0) begin
          tx_cnt_nx = tx_cnt - 16'd1;
        end else begin
          tx_state_nx = TX_IDLE;
          tx_end      = 1'b1;
        end
      end
      default: begin
        tx_state_nx = TX_IDLE;
        tx_line_nx  = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control register and optional transmit-done interrupt
  // ---------------------------------------------------------------------------
  // Receive interrupt enable.
  always_ff @(posedge wb_clk_i or negedge rst_n_i) begin
    if (!rst_n_i)     rx_ie <= 1'b1;
    else if (wr_ctrl) rx_ie <= wb_datw_i[0];
  end

`ifdef UART_TX_IRQ_EN
  // tx_done: end of stop bit sets it (winning over a same-edge clear).
  always_ff @(posedge wb_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tx_done <= 1'b0;
      tx_ie   <= 1'b0;
    end else begin
      if (wr_data || rd_status) tx_done <= 1'b0;
      if (tx_end)               tx_done <= 1'b1;
      if (wr_ctrl)              tx_ie   <= wb_datw_i[1];
    end
  end
`else
  assign tx_done = 1'b0;
  assign tx_ie   = 1'b0;
`endif

  assign int_o = (rx_valid & rx_ie) | (tx_done & tx_ie);

  // Read mux, combinational from the address and current register state.
  always_comb begin
    wb_datr_o = '0;
    case (wb_addr_i)
      2'd0:    wb_datr_o = rx_data;
      2'd1:    wb_datr_o = {3'b000, tx_done, frame_err, overrun, tx_busy, rx_valid};
      2'd2:    wb_datr_o = {6'b000000, tx_ie, rx_ie};
      default: wb_datr_o = '0;
    endcase
  end

endmodule

// File: tb/tb_uart_wb_slave.sv
// Directed bench for uart_wb_slave at BAUD_DIV=8: received bytes are pushed to
// a queue when the bench sends a frame and popped when the data register is read;
// transmitted bits are pushed when a write is issued and popped while tx_o is sampled.
module tb_uart_wb_slave;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wb_cyc = 1'b0;
  logic       wb_we = 1'b0;
  logic [1:0] wb_addr = 2'd0;
  logic [7:0] wb_datw = 8'h00;
  logic [7:0] wb_datr;
  logic       int_line;
  logic       rx_drv = 1'b1;
  logic       loop = 1'b0;
  logic       rx_line;
  logic       tx_line;

  int unsigned checks = 0;
  int unsigned failures = 0;

  // Scoreboards and a small model of the receive status bits.
  logic [7:0] rxq[$];
  logic       txq[$];
  logic       m_valid = 1'b0;
  logic       m_overrun = 1'b0;
  logic       m_ferr = 1'b0;

  assign rx_line = loop ? tx_line : rx_drv;

  uart_wb_slave #(.BAUD_DIV(8)) dut (
    .wb_clk_i  (clk),
    .rst_n_i   (rst_n),
    .wb_cyc_i  (wb_cyc),
    .wb_we_i   (wb_we),
    .wb_addr_i (wb_addr),
    .wb_datw_i (wb_datw),
    .wb_datr_o (wb_datr),
    .int_o     (int_line),
    .rx_i      (rx_line),
    .tx_o      (tx_line)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  // Look at the read mux without a bus access.
  task automatic peek(input logic [1:0] a, output logic [7:0] d);
    wb_addr = a;
    #1 d = wb_datr;
  endtask

  // Bus read: data sampled just before the access edge.
  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    wb_cyc = 1'b1; wb_we = 1'b0; wb_addr = a;
    #1 d = wb_datr;
    @(posedge clk); @(negedge clk);
    wb_cyc = 1'b0;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    wb_cyc = 1'b1; wb_we = 1'b1; wb_addr = a; wb_datw = d;
    @(posedge clk); @(negedge clk);
    wb_cyc = 1'b0; wb_we = 1'b0;
  endtask

  task automatic read_status(input string tag);
    logic [7:0] d;
    bus_read(2'd1, d);
    check(tag, d, {4'b0000, m_ferr, m_overrun, 1'b0, m_valid});
    m_overrun = 1'b0;
    m_ferr = 1'b0;
  endtask

  task automatic read_data(input string tag, output logic [7:0] d);
    logic [7:0] exp;
    exp = (rxq.size() > 0) ? rxq.pop_front() : 8'hxx;
    bus_read(2'd0, d);
    check(tag, d, exp);
    m_valid = 1'b0;
  endtask

  // Drive one 8N1 frame on rx_i and update the model with its expected effect.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx_drv = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      repeat (8) @(negedge clk);
    end
    rx_drv = stop;
    repeat (8) @(negedge clk);
    rx_drv = 1'b1;
    repeat (4) @(negedge clk);
    if (stop) begin
      if (m_valid) begin
        void'(rxq.pop_front());
        m_overrun = 1'b1;
      end
      rxq.push_back(b);
      m_valid = 1'b1;
    end else begin
      m_ferr = 1'b1;
    end
  endtask

  task automatic wait_int(input string tag);
    int unsigned n = 0;
    while (int_line !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check(tag, {7'b0, int_line}, 8'h01);
  endtask

  initial begin
    logic [7:0] d;
    logic [7:0] b;
    logic       exp_bit;
    logic       stayed_high;
    logic [7:0] loop_bytes [3];
    loop_bytes[0] = 8'h00;
    loop_bytes[1] = 8'hFF;
    loop_bytes[2] = 8'h55;

    // Reset values, observed while reset is held
    repeat (3) @(negedge clk);
    check("rst_tx", {7'b0, tx_line}, 8'h01);
    check("rst_int", {7'b0, int_line}, 8'h00);
    peek(2'd0, d); check("rst_data", d, 8'h00);
    peek(2'd1, d); check("rst_status", d, 8'h00);
    peek(2'd2, d); check("rst_ctrl", d, 8'h01);
    peek(2'd3, d); check("rst_addr3", d, 8'h00);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Receive 8'hA5; interrupt drops the cycle after the data read
    send_frame(8'hA5, 1'b1);
    check("a5_int", {7'b0, int_line}, 8'h01);
    read_data("a5_data", d);
    check("a5_int_clear", {7'b0, int_line}, 8'h00);

    // Transmit 8'h3C, a second write mid-frame must be ignored
    b = 8'h3C;
    txq.push_back(1'b0);
    for (int i = 0; i < 8; i++) txq.push_back(b[i]);
    txq.push_back(1'b1);
    bus_write(2'd0, b);
    for (int c = 0; c <= 80; c++) begin
      if (c % 8 == 4) begin
        exp_bit = txq.pop_front();
        check($sformatf("tx_bit%0d", c / 8), {7'b0, tx_line}, {7'b0, exp_bit});
      end
      if (c == 79) begin peek(2'd1, d); check("tx_busy_last", d, 8'h02); end
      if (c == 80) begin peek(2'd1, d); check("tx_busy_done", d, 8'h00); end
      wb_cyc = (c == 20); wb_we = 1'b1; wb_addr = 2'd0; wb_datw = 8'hFF;
      @(posedge clk); @(negedge clk);
    end
    wb_cyc = 1'b0; wb_we = 1'b0;
    stayed_high = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (tx_line !== 1'b1) stayed_high = 1'b0;
    end
    check("tx_idle_after", {7'b0, stayed_high}, 8'h01);

    // Overrun: two frames with no read in between
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    read_status("ovr_status1");
    read_status("ovr_status2");
    read_data("ovr_data", d);

    // Framing error, then a short low glitch
    send_frame(8'h5A, 1'b0);
    check("ferr_int", {7'b0, int_line}, 8'h00);
    read_status("ferr_status");
    rx_drv = 1'b0;
    repeat (2) @(negedge clk);
    rx_drv = 1'b1;
    repeat (100) @(negedge clk);
    read_status("glitch_status");

    // Loopback echo
    loop = 1'b1;
    for (int k = 0; k < 3; k++) begin
      b = loop_bytes[k];
      bus_write(2'd0, b);
      wait_int($sformatf("loop_int_a%0d", k));
      rxq.push_back(b); m_valid = 1'b1;
      read_data($sformatf("loop_rx_a%0d", k), d);
      repeat (4) @(negedge clk);
      bus_write(2'd0, d);
      wait_int($sformatf("loop_int_b%0d", k));
      rxq.push_back(b); m_valid = 1'b1;
      read_data($sformatf("loop_rx_b%0d", k), d);
      repeat (100) @(negedge clk);
    end
    loop = 1'b0;

    // Reset during transmit of bit 3
    bus_write(2'd0, 8'hAA);
    repeat (36) @(negedge clk);
    rst_n = 1'b0;
    #1 check("rst_mid_tx", {7'b0, tx_line}, 8'h01);
    rxq.delete(); m_valid = 1'b0; m_overrun = 1'b0; m_ferr = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    peek(2'd1, d); check("rst_mid_status", d, 8'h00);
    peek(2'd2, d); check("rst_mid_ctrl", d, 8'h01);
    stayed_high = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (tx_line !== 1'b1) stayed_high = 1'b0;
    end
    check("rst_no_resume", {7'b0, stayed_high}, 8'h01);
    check("rst_no_int", {7'b0, int_line}, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
